// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit constants and validity check for the BCD counter slice.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  function automatic logic bcd_valid(input bcd_digit_t digit);
    return (digit <= BCD_NINE);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the ripple chain: increments on carry-in, decrements on borrow-in.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  input  logic       cin,
  input  logic       bin,
  output logic [3:0] digit_out,
  output logic       cout,
  output logic       bout
);

  always_comb begin
    digit_out = digit_in;
    cout      = 1'b0;
    bout      = 1'b0;
    if (cin) begin
      if (digit_in == BCD_NINE) begin
        digit_out = BCD_ZERO;
        cout      = 1'b1;
      end else begin
        digit_out = digit_in + 4'd1;
      end
    end else if (bin) begin
      if (digit_in == BCD_ZERO) begin
        digit_out = BCD_NINE;
        bout      = 1'b1;
      end else begin
        digit_out = digit_in - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_counter_register.sv
// Multi-digit packed BCD up/down counter with set, validated load and wrap/saturate limits.
module bcd_counter_register
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SATURATE = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                set,
  input  logic                load,
  input  logic                inc,
  input  logic                dec,
  input  logic [4*DIGITS-1:0] D,
  output logic [4*DIGITS-1:0] Q,
  output logic                at_max,
  output logic                at_zero,
  output logic                ovf,
  output logic                unf,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL_NINE = {DIGITS{BCD_NINE}};
  localparam logic [W-1:0] ALL_ZERO = '0;

  logic [W-1:0]    q_q, q_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            lerr_q, lerr_d;
  logic [W-1:0]    step_val;
  logic [DIGITS:0] carry;
  logic [DIGITS:0] borrow;
  logic            d_valid;

  // inc and dec together cancel, so neither chain is started
  assign carry[0]  = inc & ~dec;
  assign borrow[0] = dec & ~inc;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .digit_in  (q_q[4*g +: 4]),
      .cin       (carry[g]),
      .bin       (borrow[g]),
      .digit_out (step_val[4*g +: 4]),
      .cout      (carry[g+1]),
      .bout      (borrow[g+1])
    );
  end

  always_comb begin
    d_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d_valid = d_valid & bcd_valid(D[4*i +: 4]);
    end
  end

  always_comb begin
    q_d    = q_q;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    lerr_d = 1'b0;
    if (set) begin
      q_d = ALL_NINE;
    end else if (load) begin
      // a rejected load still consumes the cycle; inc/dec are ignored
      if (d_valid) q_d = D;
      else         lerr_d = 1'b1;
    end else if (carry[DIGITS]) begin
      ovf_d = 1'b1;
      q_d   = (SATURATE != 0) ? ALL_NINE : step_val;
    end else if (borrow[DIGITS]) begin
      unf_d = 1'b1;
      q_d   = (SATURATE != 0) ? ALL_ZERO : step_val;
    end else begin
      q_d = step_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_q    <= ALL_ZERO;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      lerr_q <= lerr_d;
    end
  end

  assign Q        = q_q;
  assign at_max   = (q_q == ALL_NINE);
  assign at_zero  = (q_q == ALL_ZERO);
  assign ovf      = ovf_q;
  assign unf      = unf_q;
  assign load_err = lerr_q;

endmodule
